// File: rtl/cpu_sysid_checker.sv
// cpu_sysid_checker: Avalon-MM read master that fetches the system ID (word 0)
// and build timestamp (word 1), compares them against the expected build and
// reports pass/fail with a one-cycle done pulse.
// Optional feature macro: SYSID_CHECKER_TIMEOUT_EN adds a per-transfer stall
// counter that aborts a run after TIMEOUT_CYCLES consecutive stalled cycles.
module cpu_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd2,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1498981549,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD_ID = 2'd1,
    S_RD_TS = 2'd2,
    S_CHECK = 2'd3
  } state_t;

  // Reject stall limits that do not fit the 16-bit counter.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("cpu_sysid_checker: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_read,  w_read_nxt;
  logic                r_addr,  w_addr_nxt;
  logic [DATA_W-1:0]   r_id,    w_id_nxt;
  logic [DATA_W-1:0]   r_ts,    w_ts_nxt;
  logic                r_busy,  w_busy_nxt;
  logic                r_done,  w_done_nxt;
  logic                r_pass,  w_pass_nxt;
  logic                r_idm,   w_idm_nxt;
  logic                r_tsm,   w_tsm_nxt;
  logic                r_to,    w_to_nxt;
  logic                w_accept;
  logic                w_stall;
  logic                w_abort;

  assign w_accept = r_read & ~avm_waitrequest;
  assign w_stall  = r_read &  avm_waitrequest;

`ifdef SYSID_CHECKER_TIMEOUT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Consecutive-stall counter, restarted per transfer and per run.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_IDLE && start) || w_accept) begin
      r_stall_cnt <= '0;
    end else if (w_stall) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Abort on the stalled edge that brings the count up to the limit.
  assign w_abort = w_stall &&
                   ((17'(r_stall_cnt) + 17'd1) == 17'(TIMEOUT_CYCLES));
`else
  assign w_abort = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    w_state_nxt = r_state;
    w_read_nxt  = r_read;
    w_addr_nxt  = r_addr;
    w_id_nxt    = r_id;
    w_ts_nxt    = r_ts;
    w_done_nxt  = 1'b0;
    w_pass_nxt  = r_pass;
    w_idm_nxt   = r_idm;
    w_tsm_nxt   = r_tsm;
    w_to_nxt    = r_to;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RD_ID;
          w_read_nxt  = 1'b1;
          w_addr_nxt  = 1'b0;
          w_pass_nxt  = 1'b0;
          w_idm_nxt   = 1'b0;
          w_tsm_nxt   = 1'b0;
          w_to_nxt    = 1'b0;
        end
      end
      S_RD_ID: begin
        if (w_accept) begin
          w_id_nxt    = avm_readdata;
          w_state_nxt = S_RD_TS;
          w_addr_nxt  = 1'b1;
        end else if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_read_nxt  = 1'b0;
          w_addr_nxt  = 1'b0;
          w_to_nxt    = 1'b1;
          w_pass_nxt  = 1'b0;
          w_idm_nxt   = 1'b0;
          w_tsm_nxt   = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      S_RD_TS: begin
        if (w_accept) begin
          w_ts_nxt    = avm_readdata;
          w_state_nxt = S_CHECK;
          w_read_nxt  = 1'b0;
          w_addr_nxt  = 1'b0;
        end else if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_read_nxt  = 1'b0;
          w_addr_nxt  = 1'b0;
          w_to_nxt    = 1'b1;
          w_pass_nxt  = 1'b0;
          w_idm_nxt   = 1'b0;
          w_tsm_nxt   = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      S_CHECK: begin
        w_idm_nxt   = (r_id != EXPECTED_ID);
        w_tsm_nxt   = (r_ts != EXPECTED_TIMESTAMP);
        w_pass_nxt  = (r_id == EXPECTED_ID) && (r_ts == EXPECTED_TIMESTAMP);
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_read_nxt  = 1'b0;
        w_addr_nxt  = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // Output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_read <= 1'b0;
      r_addr <= 1'b0;
      r_id   <= '0;
      r_ts   <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_idm  <= 1'b0;
      r_tsm  <= 1'b0;
      r_to   <= 1'b0;
    end else begin
      r_read <= w_read_nxt;
      r_addr <= w_addr_nxt;
      r_id   <= w_id_nxt;
      r_ts   <= w_ts_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_pass <= w_pass_nxt;
      r_idm  <= w_idm_nxt;
      r_tsm  <= w_tsm_nxt;
      r_to   <= w_to_nxt;
    end
  end

  assign avm_read        = r_read;
  assign avm_address     = r_addr;
  assign id_value        = r_id;
  assign timestamp_value = r_ts;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign id_mismatch     = r_idm;
  assign ts_mismatch     = r_tsm;
  assign timeout         = r_to;

endmodule

// File: tb/tb_cpu_sysid_checker.sv
// Directed self-checking bench for cpu_sysid_checker with a simple sysid
// slave model (data selected by address, scripted waitrequest).
module tb_cpu_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd2;
  localparam logic [31:0] EXP_TS = 32'd1498981549;
  localparam int unsigned TB_TIMEOUT = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata;
  logic [31:0] id_value;
  logic [31:0] timestamp_value;
  logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;

  logic [31:0] id_word = EXP_ID;
  logic [31:0] ts_word = EXP_TS;
  int          ws_left = 0;
  logic        stuck0 = 1'b0;
  logic        acc_q[$];
  int          n_tests = 0;
  int          n_fail = 0;

  cpu_sysid_checker #(
    .EXPECTED_ID       (EXP_ID),
    .EXPECTED_TIMESTAMP(EXP_TS),
    .TIMEOUT_CYCLES    (TB_TIMEOUT)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .id_value       (id_value),
    .timestamp_value(timestamp_value),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .id_mismatch    (id_mismatch),
    .ts_mismatch    (ts_mismatch),
    .timeout        (timeout)
  );

  always #5 clock = ~clock;

  assign avm_readdata = avm_address ? ts_word : id_word;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave stall script; a stalled edge must leave read/address untouched.
  always @(negedge clock) begin
    if (avm_waitrequest && !stuck0)
      check("stall_hold", {30'd0, avm_read, avm_address}, 32'd3);
    if (avm_read && !avm_address && stuck0) begin
      avm_waitrequest = 1'b1;
    end else if (avm_read && avm_address && ws_left > 0) begin
      avm_waitrequest = 1'b1;
      ws_left--;
    end else begin
      avm_waitrequest = 1'b0;
    end
  end

  // Log the address of every accepted transfer.
  always @(posedge clock) begin
    if (reset_n && avm_read && !avm_waitrequest) acc_q.push_back(avm_address);
  end

  task automatic launch();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      n++;
      #1;
      if (done) break;
    end
  endtask

  task automatic check_one_cycle_done();
    @(posedge clock);
    #1 check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [31:0] idv, input logic [31:0] tsv,
                              input logic p, input logic idm, input logic tsm);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_pass"}, {31'd0, pass}, {31'd0, p});
    check({tag, "_idm"}, {31'd0, id_mismatch}, {31'd0, idm});
    check({tag, "_tsm"}, {31'd0, ts_mismatch}, {31'd0, tsm});
    check({tag, "_id"}, id_value, idv);
    check({tag, "_ts"}, timestamp_value, tsv);
  endtask

  initial begin
    int n;
    int dones;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_read", {31'd0, avm_read}, 32'd0);
    check("rst_addr", {31'd0, avm_address}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_flags", {29'd0, id_mismatch, ts_mismatch, timeout}, 32'd0);
    check("rst_id", id_value, 32'd0);
    check("rst_ts", timestamp_value, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Zero-wait good build: 3 edges start-to-done, reads at 0 then 1
    acc_q.delete();
    launch();
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_read_addr", {30'd0, avm_read, avm_address}, 32'd2);
    wait_done(n);
    check("t1_latency", n, 32'd3);
    check_result("t1", EXP_ID, EXP_TS, 1'b1, 1'b0, 1'b0);
    check("t1_timeout", {31'd0, timeout}, 32'd0);
    check("t1_nacc", acc_q.size(), 32'd2);
    if (acc_q.size() == 2) begin
      check("t1_acc0", {31'd0, acc_q[0]}, 32'd0);
      check("t1_acc1", {31'd0, acc_q[1]}, 32'd1);
    end

    // start in the done cycle launches a new run and clears pass
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    check("b2b_done_low", {31'd0, done}, 32'd0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_pass_clr", {31'd0, pass}, 32'd0);
    wait_done(n);
    check("b2b_latency", n, 32'd3);
    check("b2b_pass", {31'd0, pass}, 32'd1);
    check_one_cycle_done();

    // Wrong system ID
    id_word = 32'd3;
    launch();
    wait_done(n);
    check("t2_latency", n, 32'd3);
    check_result("t2", 32'd3, EXP_TS, 1'b0, 1'b1, 1'b0);
    check_one_cycle_done();
    check("t2_hold_idm", {31'd0, id_mismatch}, 32'd1);
    id_word = EXP_ID;

    // Wrong timestamp, differing only in the top bit
    ts_word = EXP_TS ^ 32'h8000_0000;
    launch();
    wait_done(n);
    check_result("t3", EXP_ID, EXP_TS ^ 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    ts_word = EXP_TS;
    check_one_cycle_done();

    // Four waitrequest cycles on word 1: 7 edges start-to-done
    ws_left = 4;
    launch();
    wait_done(n);
    check("t4_latency", n, 32'd7);
    check_result("t4", EXP_ID, EXP_TS, 1'b1, 1'b0, 1'b0);
    check_one_cycle_done();

    // start pulsed during RD_TS is ignored: exactly one done
    acc_q.delete();
    ws_left = 3;
    launch();
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    check("t5_in_rdts", {30'd0, avm_read, avm_address}, 32'd3);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock);
      #1 if (done) dones++;
    end
    check("t5_ndone", dones, 32'd1);
    check("t5_idle", {31'd0, busy}, 32'd0);
    check("t5_nacc", acc_q.size(), 32'd2);
    check("t5_pass", {31'd0, pass}, 32'd1);

    // Asynchronous reset in a second run's RD_ID
    launch();
    check("t6_rdid", {30'd0, avm_read, avm_address}, 32'd2);
    #2 reset_n = 1'b0;
    #1;
    check("t6_read_drop", {31'd0, avm_read}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_pass", {31'd0, pass}, 32'd0);
    check("t6_id", id_value, 32'd0);
    check("t6_ts", timestamp_value, 32'd0);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1 if (done) dones++;
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1 if (done) dones++;
    end
    check("t6_no_done", dones, 32'd0);
    check("t6_idle", {31'd0, busy}, 32'd0);

`ifdef SYSID_CHECKER_TIMEOUT_EN
    // Good run first so captured values are known, then stall word 0 forever
    launch();
    wait_done(n);
    stuck0 = 1'b1;
    launch();
    wait_done(n);
    check("to_latency", n, TB_TIMEOUT);
    check("to_done", {31'd0, done}, 32'd1);
    check("to_read", {31'd0, avm_read}, 32'd0);
    check("to_flag", {31'd0, timeout}, 32'd1);
    check("to_pass", {31'd0, pass}, 32'd0);
    check("to_flags", {30'd0, id_mismatch, ts_mismatch}, 32'd0);
    check("to_id_kept", id_value, EXP_ID);
    check("to_ts_kept", timestamp_value, EXP_TS);
    check_one_cycle_done();
    stuck0 = 1'b0;
    @(negedge clock);
    launch();
    wait_done(n);
    check("to_recover_pass", {31'd0, pass}, 32'd1);
    check("to_recover_flag", {31'd0, timeout}, 32'd0);
`else
    check("no_to_flag", {31'd0, timeout}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sysid_checker.md
# cpu_sysid_checker

Avalon-MM read master that interrogates the system-ID slave on the CPU interconnect and verifies the hardware build before firmware relies on it. On `start` it reads word 0 (system ID) and word 1 (build timestamp), captures both, compares them against compile-time expected values, and reports pass/fail with a one-cycle `done` pulse. It sits beside the sysid slave on the same fabric and feeds a status LED or a boot-gate in the top level.

## Interface
- `EXPECTED_ID`, 32'd2: value required at slave word 0.
- `EXPECTED_TIMESTAMP`, 32'd1498981549: value required at slave word 1.
- `TIMEOUT_CYCLES`, 255: consecutive stalled cycles allowed per transfer; range 1..65535; counter is 16 bits.
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request a check; sampled only in IDLE.
- `avm_address`  out  1  word select: 0 = ID, 1 = timestamp.
- `avm_read`  out  1  read strobe.
- `avm_waitrequest`  in  1  slave stall.
- `avm_readdata`  in  32  read data, valid on any edge where `avm_read`=1 and `avm_waitrequest`=0.
- `id_value`  out  32  last captured word 0.
- `timestamp_value`  out  32  last captured word 1.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse at the end of every run.
- `pass`  out  1  level; 1 only if both words matched and no timeout.
- `id_mismatch`, `ts_mismatch`  out  1 each  sticky per-run compare flags.
- `timeout`  out  1  sticky per-run abort flag.

## Operation
- States: IDLE, RD_ID, RD_TS, CHECK.
- IDLE: `start`=1 -> RD_ID; `pass`, both mismatch flags and `timeout` cleared on that edge.
- RD_ID: `avm_read`=1, `avm_address`=0; on accepted transfer capture `id_value`, -> RD_TS.
- RD_TS: `avm_read`=1, `avm_address`=1; on accepted transfer capture `timestamp_value`, -> CHECK. `avm_read` stays high across the RD_ID->RD_TS boundary.
- CHECK: `avm_read`=0; register `id_mismatch` = (`id_value` != `EXPECTED_ID`), `ts_mismatch` likewise, `pass` = neither set; assert `done`; -> IDLE.
- All compares are full 32-bit, unsigned, exact equality.
- `start` in any non-IDLE state is ignored; no queuing.
- `start` high in the cycle `done` is high launches a new run (state is IDLE there).
- Address and read are held stable while `avm_waitrequest`=1.
- Reset values: `avm_read`=0, `avm_address`=0, `id_value`=0, `timestamp_value`=0, `busy`=0, `done`=0, `pass`=0, all flags 0, state IDLE. Reset mid-run drops `avm_read` immediately (asynchronous) and discards the run without a `done`.

## Timing
- All outputs registered.
- Zero-wait slave: `start` sampled at edge E0; read of word 0 after E0; word 1 after E1; CHECK after E2; `done`/`pass` valid after E3 — 3 edges start-to-done, 2 read cycles.
- Each `avm_waitrequest` cycle adds exactly one cycle to latency.
- `done` is high for exactly one cycle; `pass`, flags and captured values hold until the next accepted `start`.

## Configuration
- `SYSID_CHECKER_TIMEOUT_EN` defined: a 16-bit stall counter, reset to 0 at each accepted transfer and on entering RD_ID, increments on each cycle with `avm_read`=1 and `avm_waitrequest`=1. Reaching `TIMEOUT_CYCLES` -> `avm_read`=0, `timeout`=1, `pass`=0, mismatch flags 0, `done` pulse, IDLE; `id_value`/`timestamp_value` keep their last captured values.
- Undefined: no counter; `timeout` tied 0; master waits indefinitely on `avm_waitrequest`.

## Test plan
- Zero-wait slave returning 2 / 1498981549, pulse `start` -> reads at addresses 0 then 1, `done` 3 edges after start, `pass`=1, flags 0.
- Slave returns word 0 = 3 -> `id_mismatch`=1, `ts_mismatch`=0, `pass`=0, `id_value`=3.
- `avm_waitrequest` held high 4 cycles on word 1 -> address/read stable throughout, `done` 7 edges after start, `pass`=1.
- With `SYSID_CHECKER_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, waitrequest stuck high on word 0 -> `avm_read` drops after 8 stalled cycles, `timeout`=1, `pass`=0, one `done`.
- `start` pulsed during RD_TS, then `reset_n` asserted during a second run's RD_ID -> first run completes once; reset clears all outputs to 0 asynchronously, no `done`.
